// File: rtl/periph_mmio.sv
// periph_mmio: memory-mapped timer, system tick, LED register and a
// scanned 4-digit hex seven-segment display on the MEM-stage data bus.
// Loads are combinational, stores take effect at the rising edge.
module periph_mmio #(
    parameter logic [31:0] BASE     = 32'h4000_0000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        sel,
    output logic        irq,
    output logic [15:0] led,
    output logic [3:0]  AN,
    output logic [7:0]  BCD
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_DIGI    = 3'd4;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    logic [31:0]   r_th;
    logic [31:0]   r_tl;
    logic [2:0]    r_tcon;
    logic [15:0]   r_led;
    logic [15:0]   r_digi;
    logic [31:0]   r_systick;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [7:0]    r_bcd;

    logic [2:0]    w_off;
    logic          w_wr;
    logic          w_tl_max;
    logic          w_ovf_set;
    logic [3:0]    w_digit;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Byte-lane bits carry no meaning for word registers.
    assign w_unused  = &{1'b0, Address[1:0]};

    assign sel       = (Address[31:5] == BASE[31:5]);
    assign w_off     = Address[4:2];
    assign w_wr      = MemWrite & sel;
    assign w_tl_max  = (r_tl == 32'hFFFF_FFFF);
    // Overflow raises the status bit only when interrupts are enabled.
    assign w_ovf_set = r_tcon[0] & r_tcon[1] & w_tl_max;

    assign irq = r_tcon[2];
    assign led = r_led;
    assign AN  = r_an;
    assign BCD = r_bcd;

    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Zero-wait load mux; reads outside the window or without MemRead give 0.
    always_comb begin
        w_rdata = 32'd0;
        if (MemRead && sel) begin
            case (w_off)
                OFF_TH:      w_rdata = r_th;
                OFF_TL:      w_rdata = r_tl;
                OFF_TCON:    w_rdata = {29'd0, r_tcon};
                OFF_LED:     w_rdata = {16'd0, r_led};
                OFF_DIGI:    w_rdata = {16'd0, r_digi};
                OFF_SYSTICK: w_rdata = r_systick;
                default:     w_rdata = 32'd0;
            endcase
        end
    end
    assign Read_data = w_rdata;

    // Plain bus-written registers: reload value, LEDs, display digits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th   <= 32'd0;
            r_led  <= 16'd0;
            r_digi <= 16'd0;
        end else if (w_wr) begin
            if (w_off == OFF_TH)   r_th   <= Write_data;
            if (w_off == OFF_LED)  r_led  <= Write_data[15:0];
            if (w_off == OFF_DIGI) r_digi <= Write_data[15:0];
        end
    end

    // Timer count: a bus write wins over both increment and reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tl <= 32'd0;
        end else if (w_wr && (w_off == OFF_TL)) begin
            r_tl <= Write_data;
        end else if (r_tcon[0]) begin
            r_tl <= w_tl_max ? r_th : (r_tl + 32'd1);
        end
    end

    // Timer control: an overflow in the same cycle as a TCON write still
    // sets the status bit so a pending interrupt is never dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcon <= 3'd0;
        end else if (w_wr && (w_off == OFF_TCON)) begin
            r_tcon <= {Write_data[2] | w_ovf_set, Write_data[1:0]};
        end else if (w_ovf_set) begin
            r_tcon[2] <= 1'b1;
        end
    end

    // Free-running system tick, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_systick <= 32'd0;
        else        r_systick <= r_systick + 32'd1;
    end

    // Scan divider: each digit stays lit for SCAN_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Nibble for the currently selected digit (digit 0 is rightmost).
    always_comb begin
        w_digit = r_digi[3:0];
        case (r_idx)
            2'd0: w_digit = r_digi[3:0];
            2'd1: w_digit = r_digi[7:4];
            2'd2: w_digit = r_digi[11:8];
            default: w_digit = r_digi[15:12];
        endcase
    end

    // Registered display drivers, blanked while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 4'hF;
            r_bcd <= 8'hFF;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_bcd <= hex_seg(w_digit);
        end
    end

endmodule

// File: tb/tb_periph_mmio.sv
// Directed bench for periph_mmio: a table of store/load vectors plus
// hand-written sequences for timer overflow, interrupt races, reset and
// display scanning.
module tb_periph_mmio;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        sel;
    logic        irq;
    logic [15:0] led;
    logic [3:0]  AN;
    logic [7:0]  BCD;

    int checks;
    int failures;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        re;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic        exp_sel;
    } vec_t;

    vec_t vecs[12];

    periph_mmio #(.BASE(BASE), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .sel        (sel),
        .irq        (irq),
        .led        (led),
        .AN         (AN),
        .BCD        (BCD)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one rising edge, then settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // store: presented before the edge, removed 1ns after it
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address    = a;
        Write_data = d;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
    endtask

    // combinational load check, consumes 1ns, no clock edge
    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        MemRead = 1'b1;
        #1;
        chk(name, Read_data, exp);
        MemRead = 1'b0;
    endtask

    task automatic rd_val(input logic [31:0] a, output logic [31:0] v);
        Address = a;
        MemRead = 1'b1;
        #1;
        v = Read_data;
        MemRead = 1'b0;
    endtask

    task automatic chk_disp(input string name, input logic [3:0] an_e, input logic [7:0] bcd_e);
        chk({name, "_an"},  {28'd0, AN},  {28'd0, an_e});
        chk({name, "_bcd"}, {24'd0, BCD}, {24'd0, bcd_e});
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 6; k++)
            rd($sformatf("%s_reg%0d", tag, k), BASE + 32'(k * 4), 32'd0);
        chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
        chk({tag, "_led"}, {16'd0, led}, 32'd0);
        chk_disp(tag, 4'hF, 8'hFF);
    endtask

    initial begin
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  exp_an;
        logic [7:0]  exp_bcd;
        int          d;

        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        Address    = 32'd0;
        Write_data = 32'd0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;

        vecs[0]  = '{1'b1, BASE + 32'h00, 32'hDEAD_BEEF, 1'b1, BASE + 32'h00, 32'hDEAD_BEEF, 1'b1};
        vecs[1]  = '{1'b1, BASE + 32'h04, 32'h1234_5678, 1'b1, BASE + 32'h04, 32'h1234_5678, 1'b1};
        vecs[2]  = '{1'b1, BASE + 32'h0C, 32'hFFFF_1234, 1'b1, BASE + 32'h0C, 32'h0000_1234, 1'b1};
        vecs[3]  = '{1'b1, BASE + 32'h10, 32'hABCD_5678, 1'b1, BASE + 32'h10, 32'h0000_5678, 1'b1};
        vecs[4]  = '{1'b1, BASE + 32'h08, 32'hFFFF_FFFA, 1'b1, BASE + 32'h08, 32'h0000_0002, 1'b1};
        vecs[5]  = '{1'b1, BASE + 32'h08, 32'h0000_0000, 1'b1, BASE + 32'h08, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 1'b1, BASE + 32'h18, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, BASE + 32'h1C, 32'h5555_AAAA, 1'b1, BASE + 32'h1C, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'd0,         32'd0,         1'b1, BASE + 32'h20, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'd0,         32'd0,         1'b1, BASE + 32'h03, 32'hDEAD_BEEF, 1'b1};
        vecs[10] = '{1'b1, BASE + 32'h07, 32'h0000_00AA, 1'b1, BASE + 32'h04, 32'h0000_00AA, 1'b1};
        vecs[11] = '{1'b0, 32'd0,         32'd0,         1'b0, BASE + 32'h0C, 32'h0000_0000, 1'b1};

        // power-on reset
        #22;
        chk_all_zero("por");
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk_disp("release", 4'hE, 8'hC0);

        // table-driven store/load vectors (timer disabled throughout)
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
            Address = vecs[i].raddr;
            MemRead = vecs[i].re;
            #1;
            chk($sformatf("vec%0d_rd", i),  Read_data,         vecs[i].exp_rd);
            chk($sformatf("vec%0d_sel", i), {31'd0, sel},      {31'd0, vecs[i].exp_sel});
            MemRead = 1'b0;
        end
        chk("led_out", {16'd0, led}, 32'h0000_1234);

        // timer overflow with reload and interrupt
        bus_write(BASE + 32'h00, 32'hFFFF_FFF0);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h08, 32'h0000_0003);
        rd("ovf_e0_tl", BASE + 32'h04, 32'hFFFF_FFFE);
        tick();
        rd("ovf_e1_tl", BASE + 32'h04, 32'hFFFF_FFFF);
        chk("ovf_e1_irq", {31'd0, irq}, 32'd0);
        tick();
        rd("ovf_e2_tl", BASE + 32'h04, 32'hFFFF_FFF0);
        rd("ovf_e2_tcon", BASE + 32'h08, 32'h0000_0007);
        chk("ovf_e2_irq", {31'd0, irq}, 32'd1);
        tick();
        rd("ovf_e3_tl", BASE + 32'h04, 32'hFFFF_FFF1);
        bus_write(BASE + 32'h08, 32'h0000_0000);
        chk("ovf_clr_irq", {31'd0, irq}, 32'd0);

        // interrupt clear race: TCON write on the overflow edge keeps the set
        bus_write(BASE + 32'h00, 32'hFFFF_FFFD);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFD);
        bus_write(BASE + 32'h08, 32'h0000_0003);
        tick();
        tick();
        rd("race_tl_max1", BASE + 32'h04, 32'hFFFF_FFFF);
        tick();
        chk("race_first_irq", {31'd0, irq}, 32'd1);
        tick();
        tick();
        rd("race_tl_max2", BASE + 32'h04, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h08, 32'h0000_0003);
        rd("race_ovf_tcon", BASE + 32'h08, 32'h0000_0007);
        chk("race_ovf_irq", {31'd0, irq}, 32'd1);
        bus_write(BASE + 32'h08, 32'h0000_0003);
        rd("race_plain_tcon", BASE + 32'h08, 32'h0000_0003);
        chk("race_plain_irq", {31'd0, irq}, 32'd0);
        bus_write(BASE + 32'h08, 32'h0000_0000);

        // TL write beats increment
        bus_write(BASE + 32'h08, 32'h0000_0001);
        bus_write(BASE + 32'h04, 32'h0000_0005);
        rd("tlw_now", BASE + 32'h04, 32'h0000_0005);
        tick();
        rd("tlw_next", BASE + 32'h04, 32'h0000_0006);
        bus_write(BASE + 32'h08, 32'h0000_0000);

        // SYSTICK: store ignored, reads track elapsed cycles
        rd_val(BASE + 32'h14, s1);
        bus_write(BASE + 32'h14, 32'h0000_0000);
        rd_val(BASE + 32'h14, s2);
        chk("systick_wr_ignored", s2 - s1, 32'd1);
        rd_val(BASE + 32'h14, s1);
        repeat (7) tick();
        rd_val(BASE + 32'h14, s2);
        chk("systick_delta7", s2 - s1, 32'd7);

        // reset mid-operation: timer running with pending irq, LEDs and digits set
        bus_write(BASE + 32'h0C, 32'h0000_ABCD);
        bus_write(BASE + 32'h10, 32'h0000_0005);
        bus_write(BASE + 32'h08, 32'h0000_0007);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        reset = 1'b1;

        // display scan: DIGI written on the first edge after release
        bus_write(BASE + 32'h10, 32'h0000_12AF);
        chk_disp("scan_e1", 4'hE, 8'hC0);
        for (int e = 2; e <= 17; e++) begin
            tick();
            d = ((e - 1) / 4) % 4;
            case (d)
                0: begin exp_an = 4'hE; exp_bcd = 8'h8E; end
                1: begin exp_an = 4'hD; exp_bcd = 8'h88; end
                2: begin exp_an = 4'hB; exp_bcd = 8'hA4; end
                default: begin exp_an = 4'h7; exp_bcd = 8'hF9; end
            endcase
            chk_disp($sformatf("scan_e%0d", e), exp_an, exp_bcd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
